// File: rtl/waterfall_if.sv
// Bundles the bin stream, pixel read port, BRAM ports and status of the waterfall controller.
// master = sources/display/BRAM side, slave = the controller.
interface waterfall_if #(
  parameter int BINS_W  = 5,
  parameter int LINES_W = 4,
  parameter int DATA_W  = 8
);
  localparam int ADDR_W = LINES_W + BINS_W;

  logic [DATA_W-1:0]  bin_data;
  logic               bin_valid;
  logic               bin_last;
  logic               bin_ready;
  logic               freeze;
  logic               clear_req;
  logic               pix_req;
  logic [LINES_W-1:0] pix_row;
  logic [BINS_W-1:0]  pix_col;
  logic               pix_valid;
  logic [DATA_W-1:0]  pix_data;
  logic [ADDR_W-1:0]  ram_w_addr;
  logic               ram_w_en;
  logic [DATA_W-1:0]  ram_d_in;
  logic [ADDR_W-1:0]  ram_r_addr;
  logic               ram_r_en;
  logic [DATA_W-1:0]  ram_d_out;
  logic [LINES_W-1:0] head_line;
  logic               line_done;
  logic               drop_err;
  logic               busy;

  modport master (
    output bin_data, bin_valid, bin_last, freeze, clear_req,
    output pix_req, pix_row, pix_col, ram_d_out,
    input  bin_ready, pix_valid, pix_data,
    input  ram_w_addr, ram_w_en, ram_d_in, ram_r_addr, ram_r_en,
    input  head_line, line_done, drop_err, busy
  );

  modport slave (
    input  bin_data, bin_valid, bin_last, freeze, clear_req,
    input  pix_req, pix_row, pix_col, ram_d_out,
    output bin_ready, pix_valid, pix_data,
    output ram_w_addr, ram_w_en, ram_d_in, ram_r_addr, ram_r_en,
    output head_line, line_done, drop_err, busy
  );
endinterface

// File: rtl/waterfall_ctrl.sv
// Circular waterfall store over a dual-port BRAM: bins write 1 cycle after accept, pixels return 2 cycles after request.
// bin_ready drops in CLEAR, on freeze and on clear_req; reads are never back-pressured.
module waterfall_ctrl #(
  parameter int BINS_W  = 5,
  parameter int LINES_W = 4,
  parameter int DATA_W  = 8
) (
  input logic        clk,
  input logic        reset_n,
  waterfall_if.slave wf
);
  localparam int ADDR_W = LINES_W + BINS_W;

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  sweep_q;
  logic [LINES_W-1:0] head_q, filled_q;
  logic [BINS_W-1:0]  col_q;
  logic               w_en_q;
  logic [ADDR_W-1:0]  w_addr_q;
  logic [DATA_W-1:0]  w_dat_q;
  logic               line_done_q, drop_err_q;
  logic               rd_req_q, rd_live_q, pix_vld_q, pix_live_q;
  logic [ADDR_W-1:0]  r_addr_q;
  logic [LINES_W-1:0] rd_line;
  logic               accept, col_end, commit, discard;

  assign accept  = wf.bin_valid && wf.bin_ready;
  assign col_end = &col_q;
  assign commit  = accept && col_end && wf.bin_last;
  assign discard = accept && (col_end ^ wf.bin_last);
  assign rd_line = head_q - wf.pix_row - LINES_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (!wf.clear_req && (&sweep_q)) state_d = RUN;
      RUN:     if (wf.clear_req) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Write side: sweep writes in CLEAR, registered bin writes in RUN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sweep_q     <= '0;
      head_q      <= '0;
      filled_q    <= '0;
      col_q       <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_dat_q     <= '0;
      line_done_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      w_en_q      <= 1'b0;
      line_done_q <= 1'b0;
      drop_err_q  <= 1'b0;
      if (wf.clear_req) begin
        sweep_q  <= '0;
        head_q   <= '0;
        filled_q <= '0;
        col_q    <= '0;
      end else if (state_q == CLEAR) begin
        w_en_q   <= 1'b1;
        w_addr_q <= sweep_q;
        w_dat_q  <= '0;
        sweep_q  <= sweep_q + ADDR_W'(1);
      end else if (accept) begin
        w_en_q   <= 1'b1;
        w_addr_q <= {head_q, col_q};
        w_dat_q  <= wf.bin_data;
        if (commit) begin
          col_q       <= '0;
          head_q      <= head_q + LINES_W'(1);
          filled_q    <= (&filled_q) ? filled_q : filled_q + LINES_W'(1);
          line_done_q <= 1'b1;
        end else if (discard) begin
          // Partial data stays in the head line, which is never readable.
          col_q      <= '0;
          drop_err_q <= 1'b1;
        end else begin
          col_q <= col_q + BINS_W'(1);
        end
      end
    end
  end

  // Read side: rows at or beyond the filled count skip the BRAM and return zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_req_q   <= 1'b0;
      rd_live_q  <= 1'b0;
      r_addr_q   <= '0;
      pix_vld_q  <= 1'b0;
      pix_live_q <= 1'b0;
    end else begin
      rd_req_q   <= wf.pix_req;
      rd_live_q  <= wf.pix_req && (wf.pix_row < filled_q);
      if (wf.pix_req) r_addr_q <= {rd_line, wf.pix_col};
      pix_vld_q  <= rd_req_q;
      pix_live_q <= rd_live_q;
    end
  end

  assign wf.bin_ready  = (state_q == RUN) && !wf.freeze && !wf.clear_req;
  assign wf.busy       = (state_q == CLEAR);
  assign wf.ram_w_en   = w_en_q;
  assign wf.ram_w_addr = w_addr_q;
  assign wf.ram_d_in   = w_dat_q;
  assign wf.ram_r_en   = rd_live_q;
  assign wf.ram_r_addr = r_addr_q;
  assign wf.pix_valid  = pix_vld_q;
  assign wf.pix_data   = pix_live_q ? wf.ram_d_out : '0;
  assign wf.head_line  = head_q;
  assign wf.line_done  = line_done_q;
  assign wf.drop_err   = drop_err_q;
endmodule
